wire_ops_arb: RTL and testbench
===============================

Name: wire_ops_arb

Overview:
Round-robin arbiter and sequencer that shares one 8-bit AND/XOR-select datapath with an enabled result register among NREQ requesters. Each requester presents operands and an op select over valid/ready. The block grants one request per cycle, computes the result into a single output register and returns it with the requester index over a valid/ready response channel. It sits between requester front-ends and the downstream consumer of WireOps-style results.

Parameters:
NREQ, 4, number of requesters (1..16; need not be a power of 2)
W, 8, operand/result width
IDW, 2, width of rsp_id; must satisfy 2^IDW >= NREQ
CNTW, 16, width of the completed-operation counter

Ports:
sys_clk  in  1  clock; all state updates on the rising edge
sys_rst  in  1  reset, synchronous, active-low (sys_rst=0 resets on the next rising edge)
req_valid  in  NREQ  per-requester request valid
req_ready  out  NREQ  per-requester accept; at most one bit set
req_a  in  NREQ*W  operand a, requester i at bits [i*W +: W]
req_b  in  NREQ*W  operand b, same packing
req_sel  in  NREQ  op select per requester: 1 = a&b, 0 = a^b
rsp_valid  out  1  result register holds a valid result
rsp_ready  in  1  consumer accepts the result
rsp_data  out  W  result
rsp_id  out  IDW  index of the requester that produced rsp_data
op_count  out  CNTW  number of accepted requests, wraps modulo 2^CNTW

Behaviour:
- accept = !rsp_valid | rsp_ready. The output stage is empty or draining this cycle.
- Grant is combinational round-robin over req_valid. Search starts at ptr and proceeds upward with wrap at NREQ-1 -> 0. The first valid index is g.
- req_ready[g] = accept & req_valid[g]; all other bits are 0. fire = |(req_valid & req_ready).
- On fire:
  - rsp_data <= req_sel[g] ? (a_g & b_g) : (a_g ^ b_g)
  - rsp_id <= g, rsp_valid <= 1
  - ptr <= (g == NREQ-1) ? 0 : g+1
  - op_count <= op_count+1, wrapping
- No fire and rsp_ready=1: rsp_valid <= 0. rsp_data and rsp_id keep their values (don't-care).
- rsp_valid=1 and rsp_ready=0: rsp_data, rsp_id and rsp_valid hold. No req_ready is asserted. ptr holds.
- No fire: ptr holds. The pointer never advances on an idle cycle.
- Latency is 1 cycle from the fire edge to rsp_valid. Throughput is 1 result/cycle while rsp_ready=1.
- Fire and drain in the same cycle: the new result replaces the old one and rsp_valid stays 1, with no bubble.
- Requester contract: req_valid, once raised, must hold with stable operands until req_ready. The arbiter does not check this.
- NREQ=1: grant is always index 0 and ptr is constant 0.
- Reset (sys_rst=0 at an edge): rsp_valid=0, rsp_data=0, rsp_id=0, ptr=0, op_count=0. req_ready is 0 during the reset cycle. A pending result is discarded on mid-operation reset. The first grant after release starts at index 0.
- All arithmetic is W-bit bitwise with no carries. The ptr comparison is unsigned IDW-bit.

Decomposition:
- Shared package wire_ops_pkg:
  - OP_XOR=1'b0, OP_AND=1'b1
  - default W
  - typedef of the response struct {id, data}
- One sub-module, wire_ops_rr_pick: purely combinational.
  - Inputs: req vector, ptr.
  - Outputs: one-hot grant, index g, any_valid.
- The top level holds ptr, the result register and op_count.

Test Plan:
- Reset then single request: req_valid=0001, a=0xF0, b=0x3C, sel=1 -> req_ready=0001 in that cycle; next cycle rsp_valid=1, rsp_data=0x30, rsp_id=0, op_count=1.
- All four requesters valid continuously, rsp_ready=1, sel=0, a_i=i, b_i=0xFF -> grants 0,1,2,3,0 on consecutive cycles; rsp_data = 0xFF,0xFE,0xFD,0xFC; rsp_id = 0,1,2,3,0.
- Backpressure: rsp_ready=0 for 3 cycles with req_valid=1111 -> req_ready=0000; rsp_data/rsp_id stable; ptr unchanged. On release, the next grant is ptr's index and rsp has no bubble.
- Sparse requests: after a grant to 2, only req_valid[1]=1 -> grant 1 (wraps past 3,0); ptr becomes 2.
- Mid-operation reset: sys_rst=0 while rsp_valid=1, rsp_ready=0 -> next edge rsp_valid=0, op_count=0; after release with req_valid=1111 the first grant is 0.
- Counter wrap (CNTW=4): 17 accepted requests -> op_count=1.

Source files
------------

// File: rtl/wire_ops_pkg.sv
// Shared definitions for the wire-ops arbiter: op encodings, default widths
// and the response payload layout.
package wire_ops_pkg;

    localparam int unsigned W_DEF   = 8;
    localparam int unsigned IDW_DEF = 2;

    localparam logic OP_XOR = 1'b0;
    localparam logic OP_AND = 1'b1;

    typedef struct packed {
        logic [IDW_DEF-1:0] id;
        logic [W_DEF-1:0]   data;
    } rsp_t;

endpackage

// File: rtl/wire_ops_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr,
// otherwise the first set request from index 0.
module wire_ops_rr_pick
    import wire_ops_pkg::*;
#(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDW  = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  idx,
    output logic            any_valid
);

    // Two passes avoid modular index arithmetic: upper segment first, then wrap.
    always_comb begin
        grant     = '0;
        idx       = '0;
        any_valid = 1'b0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (!any_valid && req[i] && (i >= 32'(ptr))) begin
                any_valid = 1'b1;
                grant[i]  = 1'b1;
                idx       = IDW'(i);
            end
        end
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (!any_valid && req[i]) begin
                any_valid = 1'b1;
                grant[i]  = 1'b1;
                idx       = IDW'(i);
            end
        end
    end

endmodule

// File: rtl/wire_ops_arb.sv
// Round-robin arbiter sharing one AND/XOR datapath and result register among
// NREQ requesters, with a valid/ready response channel and an accept counter.
module wire_ops_arb
    import wire_ops_pkg::*;
#(
    parameter int unsigned NREQ = 4,
    parameter int unsigned W    = W_DEF,
    parameter int unsigned IDW  = IDW_DEF,
    parameter int unsigned CNTW = 16
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*W-1:0] req_a,
    input  logic [NREQ*W-1:0] req_b,
    input  logic [NREQ-1:0]   req_sel,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [W-1:0]      rsp_data,
    output logic [IDW-1:0]    rsp_id,
    output logic [CNTW-1:0]   op_count
);

    logic [IDW-1:0]  ptr;
    logic [NREQ-1:0] grant;
    logic [IDW-1:0]  g;
    logic            any_valid;
    logic            accept;
    logic            fire;
    logic [W-1:0]    a_g;
    logic [W-1:0]    b_g;
    logic            sel_g;
    logic [W-1:0]    result_c;
    logic [IDW-1:0]  ptr_nxt;

    wire_ops_rr_pick #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_pick (
        .req       (req_valid),
        .ptr       (ptr),
        .grant     (grant),
        .idx       (g),
        .any_valid (any_valid)
    );

    // Output stage can take a new result when empty or draining; nothing is
    // granted while reset is asserted.
    assign accept    = !rsp_valid || rsp_ready;
    assign req_ready = (sys_rst && accept) ? grant : '0;
    assign fire      = sys_rst && accept && any_valid;

    // Operand mux driven by the one-hot grant.
    always_comb begin
        a_g   = '0;
        b_g   = '0;
        sel_g = OP_XOR;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                a_g   = req_a[i*W +: W];
                b_g   = req_b[i*W +: W];
                sel_g = req_sel[i];
            end
        end
    end

    assign result_c = (sel_g == OP_AND) ? (a_g & b_g) : (a_g ^ b_g);
    assign ptr_nxt  = (g == IDW'(NREQ - 1)) ? '0 : g + IDW'(1);

    always_ff @(posedge sys_clk) begin
        if (!sys_rst) begin
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_id    <= '0;
            ptr       <= '0;
            op_count  <= '0;
        end else if (fire) begin
            rsp_valid <= 1'b1;
            rsp_data  <= result_c;
            rsp_id    <= g;
            ptr       <= ptr_nxt;
            op_count  <= op_count + CNTW'(1);
        end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_wire_ops_arb.sv
// Directed bench for wire_ops_arb: per-cycle comparison against a queue-free
// round-robin model, plus literal checks taken from the worked examples.
module tb_wire_ops_arb;
    import wire_ops_pkg::*;

    localparam int unsigned NREQ = 4;
    localparam int unsigned W    = 8;
    localparam int unsigned IDW  = 2;

    logic              sys_clk = 1'b0;
    logic              sys_rst;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ-1:0]   req_ready4;
    logic [NREQ*W-1:0] req_a;
    logic [NREQ*W-1:0] req_b;
    logic [NREQ-1:0]   req_sel;
    logic              rsp_valid, rsp_valid4;
    logic              rsp_ready;
    logic [W-1:0]      rsp_data, rsp_data4;
    logic [IDW-1:0]    rsp_id, rsp_id4;
    logic [15:0]       op_count;
    logic [3:0]        op_count4;

    int tests = 0;
    int fails = 0;

    always #5 sys_clk = ~sys_clk;

    wire_ops_arb #(.NREQ(NREQ), .W(W), .IDW(IDW), .CNTW(16)) u_dut (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_sel   (req_sel),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id),
        .op_count  (op_count)
    );

    // Narrow-counter instance to observe the wrap.
    wire_ops_arb #(.NREQ(NREQ), .W(W), .IDW(IDW), .CNTW(4)) u_dut4 (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .req_valid (req_valid),
        .req_ready (req_ready4),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_sel   (req_sel),
        .rsp_valid (rsp_valid4),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data4),
        .rsp_id    (rsp_id4),
        .op_count  (op_count4)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model state: what the result register, pointer and counter must hold.
    rsp_t m_rsp;
    logic m_valid = 1'b0;
    int   m_ptr   = 0;
    int   m_cnt   = 0;
    bit   m_init  = 1'b0;

    always @(negedge sys_clk) begin
        int g;
        logic [NREQ-1:0] exp_rdy;
        logic [W-1:0] a, b;
        g = -1;
        exp_rdy = '0;
        if (sys_rst && (!m_valid || rsp_ready)) begin
            for (int k = 0; k < NREQ; k++) begin
                int idx;
                idx = (m_ptr + k) % NREQ;
                if (g < 0 && req_valid[idx]) g = idx;
            end
        end
        if (g >= 0) exp_rdy[g] = 1'b1;
        if (m_init) begin
            chk("model req_ready", 32'(req_ready), 32'(exp_rdy));
            chk("model req_ready4", 32'(req_ready4), 32'(exp_rdy));
            chk("model rsp_valid", 32'(rsp_valid), 32'(m_valid));
            chk("model rsp_data", 32'(rsp_data), 32'(m_rsp.data));
            chk("model rsp_id", 32'(rsp_id), 32'(m_rsp.id));
            chk("model op_count", 32'(op_count), 32'(m_cnt % 65536));
            chk("model op_count4", 32'(op_count4), 32'(m_cnt % 16));
        end
        if (!sys_rst) begin
            m_valid = 1'b0;
            m_rsp   = '0;
            m_ptr   = 0;
            m_cnt   = 0;
            m_init  = 1'b1;
        end else if (m_init) begin
            if (g >= 0) begin
                a = req_a[g*W +: W];
                b = req_b[g*W +: W];
                m_rsp.data = req_sel[g] ? (a & b) : (a ^ b);
                m_rsp.id   = IDW'(g);
                m_valid    = 1'b1;
                m_ptr      = (g + 1) % NREQ;
                m_cnt      = m_cnt + 1;
            end else if (rsp_ready) begin
                m_valid = 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    int eg[5] = '{0, 1, 2, 3, 0};
    logic [7:0] ed[5] = '{8'hFF, 8'hFE, 8'hFD, 8'hFC, 8'hFF};

    initial begin
        sys_rst   = 1'b0;
        rsp_ready = 1'b1;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        req_sel   = '0;
        tick();
        tick();
        chk("reset rsp_valid", 32'(rsp_valid), 0);
        chk("reset rsp_data", 32'(rsp_data), 0);
        chk("reset rsp_id", 32'(rsp_id), 0);
        chk("reset op_count", 32'(op_count), 0);

        // Single AND request from requester 0.
        sys_rst     = 1'b1;
        req_valid   = 4'b0001;
        req_a[7:0]  = 8'hF0;
        req_b[7:0]  = 8'h3C;
        req_sel     = 4'b0001;
        settle();
        chk("single req_ready", 32'(req_ready), 32'h1);
        tick();
        chk("single rsp_valid", 32'(rsp_valid), 1);
        chk("single rsp_data", 32'(rsp_data), 32'h30);
        chk("single rsp_id", 32'(rsp_id), 0);
        chk("single op_count", 32'(op_count), 1);
        req_valid = '0;
        tick();
        chk("drain rsp_valid", 32'(rsp_valid), 0);

        // Fresh reset, then all four requesters XOR continuously.
        sys_rst = 1'b0;
        tick();
        sys_rst = 1'b1;
        for (int i = 0; i < NREQ; i++) begin
            req_a[i*W +: W] = 8'(i);
            req_b[i*W +: W] = 8'hFF;
        end
        req_sel   = 4'b0000;
        req_valid = 4'b1111;
        for (int n = 0; n < 5; n++) begin
            settle();
            chk("rr req_ready", 32'(req_ready), 32'(1) << eg[n]);
            tick();
            chk("rr rsp_data", 32'(rsp_data), 32'(ed[n]));
            chk("rr rsp_id", 32'(rsp_id), 32'(eg[n]));
        end

        // Backpressure: everything holds, no grants.
        rsp_ready = 1'b0;
        for (int n = 0; n < 3; n++) begin
            settle();
            chk("bp req_ready", 32'(req_ready), 0);
            tick();
            chk("bp rsp_valid", 32'(rsp_valid), 1);
            chk("bp rsp_data", 32'(rsp_data), 32'hFF);
            chk("bp rsp_id", 32'(rsp_id), 0);
        end
        rsp_ready = 1'b1;
        settle();
        chk("release req_ready", 32'(req_ready), 32'h2);
        tick();
        chk("release rsp_valid", 32'(rsp_valid), 1);
        chk("release rsp_data", 32'(rsp_data), 32'hFE);
        chk("release rsp_id", 32'(rsp_id), 1);

        // Sparse: grant 2, then only requester 1 (wraps past 3 and 0).
        req_valid = 4'b0100;
        settle();
        chk("sparse g2 req_ready", 32'(req_ready), 32'h4);
        tick();
        chk("sparse g2 rsp_id", 32'(rsp_id), 2);
        req_valid = 4'b0010;
        settle();
        chk("sparse g1 req_ready", 32'(req_ready), 32'h2);
        tick();
        chk("sparse g1 rsp_id", 32'(rsp_id), 1);
        chk("sparse g1 rsp_data", 32'(rsp_data), 32'hFE);
        req_valid = 4'b1111;
        settle();
        chk("sparse ptr2 req_ready", 32'(req_ready), 32'h4);
        tick();

        // Mid-operation reset with a held result.
        rsp_ready = 1'b0;
        settle();
        chk("hold req_ready", 32'(req_ready), 0);
        tick();
        chk("hold rsp_valid", 32'(rsp_valid), 1);
        chk("hold rsp_id", 32'(rsp_id), 2);
        sys_rst = 1'b0;
        settle();
        chk("in-reset req_ready", 32'(req_ready), 0);
        tick();
        chk("midrst rsp_valid", 32'(rsp_valid), 0);
        chk("midrst op_count", 32'(op_count), 0);
        sys_rst   = 1'b1;
        rsp_ready = 1'b1;
        settle();
        chk("post-reset req_ready", 32'(req_ready), 32'h1);

        // 17 back-to-back accepts: narrow counter wraps to 1.
        for (int n = 0; n < 17; n++) tick();
        chk("wrap op_count", 32'(op_count), 17);
        chk("wrap op_count4", 32'(op_count4), 1);

        req_valid = '0;
        tick();
        tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
